// File: rtl/uart_rom_loader.sv
// -----------------------------------------------------------------------------
// uart_rom_loader
//
// Receives a program image over an 8N1 UART line and writes it into the
// instruction ROM write port. While a load is in progress the CPU is held in
// reset; it is released only after the frame checksum verifies. A failed load
// keeps the CPU in reset until a later verified load or a system reset.
//
// Frame: 0xA5, LEN_HI, LEN_LO, LEN words of INSTR_WIDTH/8 bytes (MSB first),
//        CHK = XOR of every data byte (length bytes excluded).
//
// Ports
//   CLK_50       in   sole clock
//   reset        in   synchronous, active-high reset
//   uart_rx      in   asynchronous serial input, idle high
//   rom_address  out  ROM write address
//   rom_data     out  ROM write data
//   rom_we       out  one-cycle ROM write strobe
//   cpu_resetN   out  active-low CPU reset (low while loading / after bad load)
//   loading      out  high from sync-byte accept until frame end
//   done         out  sticky, set on a verified load
//   error        out  sticky, set on any frame error
// -----------------------------------------------------------------------------
module uart_rom_loader #(
    parameter int unsigned INSTR_WIDTH        = 16,
    parameter int unsigned ROM_REGISTER_COUNT = 1024,
    parameter int unsigned CLK_FREQ           = 50000000,
    parameter int unsigned BAUD               = 115200,
    parameter int unsigned TIMEOUT_CYCLES     = 1000000
) (
    input  logic                                  CLK_50,
    input  logic                                  reset,
    input  logic                                  uart_rx,
    output logic [$clog2(ROM_REGISTER_COUNT)-1:0] rom_address,
    output logic [INSTR_WIDTH-1:0]                rom_data,
    output logic                                  rom_we,
    output logic                                  cpu_resetN,
    output logic                                  loading,
    output logic                                  done,
    output logic                                  error
);

    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned AW   = $clog2(ROM_REGISTER_COUNT);
    localparam int unsigned BPW  = INSTR_WIDTH / 8;
    localparam int unsigned CW   = $clog2(DIV + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_ERR
    } state_e;

    // Running checksum update: every data byte is folded in with XOR.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        chk_fold = acc ^ b;
    endfunction

    // ---------------- RX front end ----------------
    logic            rx_meta_q;
    logic            rx_sync_q;
    logic            rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q,   rx_cnt_d;
    logic [2:0]      rx_bit_q,   rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q,  frame_err_d;

    // ---------------- Loader FSM ----------------
    state_e                 state_q,    state_d;
    logic [7:0]             len_hi_q,   len_hi_d;
    logic [15:0]            len_q,      len_d;
    logic [15:0]            words_q,    words_d;
    logic [INSTR_WIDTH-1:0] word_q,     word_d;
    logic [7:0]             chk_q,      chk_d;
    logic [BIW-1:0]         byte_idx_q, byte_idx_d;
    logic [AW-1:0]          addr_q,     addr_d;
    logic [INSTR_WIDTH-1:0] rom_data_q, rom_data_d;
    logic                   rom_we_q,   rom_we_d;
    logic                   cpu_rst_n_q, cpu_rst_n_d;
    logic                   loading_q,  loading_d;
    logic                   done_q,     done_d;
    logic                   error_q,    error_d;
    logic [TW-1:0]          tmo_q,      tmo_d;

    logic [15:0]            len_s;
    logic                   len_bad_s;
    logic [INSTR_WIDTH-1:0] word_next_s;
    logic [15:0]            words_next_s;
    logic                   abort_s;

    // RX synchronizer, bit timer and byte assembly registers.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= {CW{1'b0}};
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // RX bit timer: start re-sampled at mid-bit, data/stop every DIV cycles.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = {CW{1'b0}};
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CW'(HALF - 1)) begin
                    rx_cnt_d = {CW{1'b0}};
                    rx_bit_d = 3'd0;
                    // A line that is high again at mid-bit was only a glitch.
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CW'(DIV - 1)) begin
                    rx_cnt_d   = {CW{1'b0}};
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CW'(DIV - 1)) begin
                    rx_cnt_d   = {CW{1'b0}};
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Helper values derived from the byte just received.
    always_comb begin
        len_s        = {len_hi_q, rx_shift_q};
        len_bad_s    = (len_s == 16'd0) || ({1'b0, len_s} > 17'(ROM_REGISTER_COUNT));
        word_next_s  = (word_q << 8) | INSTR_WIDTH'(rx_shift_q);
        words_next_s = words_q + 16'd1;
        abort_s      = frame_err_q || (tmo_q == TW'(TIMEOUT_CYCLES));
    end

    // Loader state and output registers.
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_hi_q    <= 8'h00;
            len_q       <= 16'd0;
            words_q     <= 16'd0;
            word_q      <= {INSTR_WIDTH{1'b0}};
            chk_q       <= 8'h00;
            byte_idx_q  <= {BIW{1'b0}};
            addr_q      <= {AW{1'b0}};
            rom_data_q  <= {INSTR_WIDTH{1'b0}};
            rom_we_q    <= 1'b0;
            cpu_rst_n_q <= 1'b1;
            loading_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            tmo_q       <= {TW{1'b0}};
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            words_q     <= words_d;
            word_q      <= word_d;
            chk_q       <= chk_d;
            byte_idx_q  <= byte_idx_d;
            addr_q      <= addr_d;
            rom_data_q  <= rom_data_d;
            rom_we_q    <= rom_we_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            loading_q   <= loading_d;
            done_q      <= done_d;
            error_q     <= error_d;
            tmo_q       <= tmo_d;
        end
    end

    // Loader next-state and output logic.
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        words_d     = words_q;
        word_d      = word_q;
        chk_d       = chk_q;
        byte_idx_d  = byte_idx_q;
        rom_data_d  = rom_data_q;
        rom_we_d    = 1'b0;
        cpu_rst_n_d = cpu_rst_n_q;
        loading_d   = loading_q;
        done_d      = done_q;
        error_d     = error_q;

        // The address steps one cycle after the write strobe, but not past
        // the last word, so it can never wrap at a full-depth load.
        if (rom_we_q && (words_q != len_q)) begin
            addr_d = addr_q + AW'(1);
        end else begin
            addr_d = addr_q;
        end

        // Inter-byte watchdog: idle and every received byte restart it.
        if ((state_q == S_IDLE) || byte_valid_q) begin
            tmo_d = {TW{1'b0}};
        end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = tmo_q;
        end

        case (state_q)
            S_IDLE: begin
                if (byte_valid_q && (rx_shift_q == SYNC)) begin
                    state_d     = S_LEN_HI;
                    loading_d   = 1'b1;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    addr_d      = {AW{1'b0}};
                    chk_d       = 8'h00;
                    byte_idx_d  = {BIW{1'b0}};
                    words_d     = 16'd0;
                    word_d      = {INSTR_WIDTH{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN_HI: begin
                if (byte_valid_q) begin
                    len_hi_d = rx_shift_q;
                    state_d  = S_LEN_LO;
                end else if (abort_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (byte_valid_q) begin
                    len_d = len_s;
                    if (len_bad_s) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (abort_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_DATA: begin
                if (byte_valid_q) begin
                    word_d = word_next_s;
                    chk_d  = chk_fold(chk_q, rx_shift_q);
                    if (byte_idx_q == BIW'(BPW - 1)) begin
                        byte_idx_d = {BIW{1'b0}};
                        rom_we_d   = 1'b1;
                        rom_data_d = word_next_s;
                        words_d    = words_next_s;
                        if (words_next_s == len_q) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BIW'(1);
                    end
                end else if (abort_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHECK: begin
                if (byte_valid_q) begin
                    loading_d = 1'b0;
                    state_d   = S_IDLE;
                    if (rx_shift_q == chk_q) begin
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (abort_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_ERR: begin
                error_d     = 1'b1;
                loading_d   = 1'b0;
                cpu_rst_n_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom_address = addr_q;
    assign rom_data    = rom_data_q;
    assign rom_we      = rom_we_q;
    assign cpu_resetN  = cpu_rst_n_q;
    assign loading     = loading_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
